// File: rtl/nios_system_sysid_checker.sv
// ----------------------------------------------------------------------------
// nios_system_sysid_checker
//
// Avalon-MM read master placed directly in front of the system-ID slave.
// After reset (when AUTO_START is set) or on a start pulse, it reads the ID
// word (address 0) and then the build timestamp word (address 1). It compares
// both words against build-time constants and reports the result to
// boot/status logic, so a bitstream/software mismatch is flagged before the
// CPU is released.
//
// Optional feature macro: SYSID_CHECK_RETRY_EN
//   defined   : on a mismatch the whole read sequence is repeated, up to
//               MAX_RETRIES extra times, before done is reported.
//   undefined : a single attempt per check; retry_count is tied to 0.
//
// Ports
//   clock           in   1   system clock
//   reset           in   1   synchronous, active-high reset
//   start           in   1   one-cycle check request; ignored while busy
//   sysid_address   out  1   slave address (0 = ID word, 1 = timestamp word)
//   sysid_readdata  in   32  slave readdata (combinational read path)
//   busy            out  1   high in every state except idle
//   done            out  1   one-cycle pulse when a check completes
//   id_match        out  1   ID word equalled EXPECTED_ID
//   ts_match        out  1   timestamp word equalled EXPECTED_TS
//   pass            out  1   id_match & ts_match
//   read_id         out  32  last captured ID word
//   read_ts         out  32  last captured timestamp word
//   retry_count     out  4   attempts beyond the first in the last check
// ----------------------------------------------------------------------------
module nios_system_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID  = 32'd0,
    parameter logic [31:0] EXPECTED_TS  = 32'd1480469370,
    parameter int unsigned READ_LATENCY = 1,
    parameter bit          AUTO_START   = 1'b1,
    parameter int unsigned MAX_RETRIES  = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        sysid_address,
    input  logic [31:0] sysid_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_match,
    output logic        ts_match,
    output logic        pass,
    output logic [31:0] read_id,
    output logic [31:0] read_ts,
    output logic [3:0]  retry_count
);

    // Both counters are 4 bits wide; out-of-range settings saturate at 15.
    localparam logic [3:0] WaitLimit  = 4'((READ_LATENCY > 15) ? 15 : READ_LATENCY);
    localparam logic [3:0] RetryLimit = 4'((MAX_RETRIES > 15) ? 15 : MAX_RETRIES);

`ifdef SYSID_CHECK_RETRY_EN
    localparam bit RetryEn = 1'b1;
`else
    localparam bit RetryEn = 1'b0;
`endif

    typedef enum logic [2:0] {
        StIdle,
        StRdId,
        StRdTs,
        StCmp,
        StDone
    } state_e;

    state_e      state_q;
    logic [3:0]  wait_q;
    logic [3:0]  retry_q;
    logic        first_q;
    logic        addr_q;
    logic        busy_q;
    logic        done_q;
    logic        id_match_q;
    logic        ts_match_q;
    logic        pass_q;
    logic [31:0] read_id_q;
    logic [31:0] read_ts_q;

    logic start_cond;
    logic wait_hit;
    logic id_ok;
    logic ts_ok;
    logic retry_take;

    // first_q is high only during the first cycle after reset is released,
    // which is when the automatic check is launched.
    assign start_cond = start | (AUTO_START & first_q);

    // readdata is sampled on the edge that ends the READ_LATENCY-th wait cycle.
    assign wait_hit = (wait_q == WaitLimit);

    assign id_ok = (read_id_q == EXPECTED_ID);
    assign ts_ok = (read_ts_q == EXPECTED_TS);

    // In the default build RetryEn is 0, so retry_q never leaves 0.
    assign retry_take = RetryEn && !(id_ok && ts_ok) && (retry_q < RetryLimit);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            wait_q     <= 4'd0;
            retry_q    <= 4'd0;
            first_q    <= 1'b1;
            addr_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            id_match_q <= 1'b0;
            ts_match_q <= 1'b0;
            pass_q     <= 1'b0;
            read_id_q  <= 32'd0;
            read_ts_q  <= 32'd0;
        end else begin
            first_q <= 1'b0;
            done_q  <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    addr_q <= 1'b0;
                    busy_q <= 1'b0;
                    if (start_cond) begin
                        id_match_q <= 1'b0;
                        ts_match_q <= 1'b0;
                        pass_q     <= 1'b0;
                        retry_q    <= 4'd0;
                        wait_q     <= 4'd0;
                        busy_q     <= 1'b1;
                        state_q    <= StRdId;
                    end
                end

                StRdId: begin
                    if (wait_hit) begin
                        read_id_q <= sysid_readdata;
                        wait_q    <= 4'd0;
                        addr_q    <= 1'b1;
                        state_q   <= StRdTs;
                    end else begin
                        wait_q <= wait_q + 4'd1;
                    end
                end

                StRdTs: begin
                    if (wait_hit) begin
                        read_ts_q <= sysid_readdata;
                        wait_q    <= 4'd0;
                        addr_q    <= 1'b0;
                        state_q   <= StCmp;
                    end else begin
                        wait_q <= wait_q + 4'd1;
                    end
                end

                StCmp: begin
                    if (retry_take) begin
                        // Match flags stay cleared and done is withheld until the
                        // final attempt.
                        retry_q <= retry_q + 4'd1;
                        addr_q  <= 1'b0;
                        state_q <= StRdId;
                    end else begin
                        id_match_q <= id_ok;
                        ts_match_q <= ts_ok;
                        pass_q     <= id_ok & ts_ok;
                        done_q     <= 1'b1;
                        state_q    <= StDone;
                    end
                end

                StDone: begin
                    // start is deliberately not looked at here.
                    busy_q  <= 1'b0;
                    addr_q  <= 1'b0;
                    state_q <= StIdle;
                end

                default: begin
                    busy_q  <= 1'b0;
                    addr_q  <= 1'b0;
                    wait_q  <= 4'd0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign sysid_address = addr_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign id_match      = id_match_q;
    assign ts_match      = ts_match_q;
    assign pass          = pass_q;
    assign read_id       = read_id_q;
    assign read_ts       = read_ts_q;

`ifdef SYSID_CHECK_RETRY_EN
    assign retry_count = retry_q;
`else
    assign retry_count = 4'd0;
`endif

endmodule
